spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI responder; counterpart to the team's spi_master.
//  - Oversamples external SPI clock and chip select on i_Clk.
//  - Single, dual and quad modes, MSB first; byte-level ready/valid interface.
//  - Sits between an SPI pad ring and a register file or FIFO.
// PARAMETERS
//  SPI_MODE     0      CPOL/CPHA mode 0..3, same encoding as spi_master
//  SYNC_STAGES  2      flops per synchronizer on SPI clock, CS_n and SIO inputs (>=2)
//  DEFAULT_TX   8'hFF  byte shifted out when no TX byte is queued
// PORTS
//  i_Clk          in     1  system clock; must be >= 8x SPI clock
//  i_Rst          in     1  synchronous, active-high reset
//  i_BUS_MODE     in     2  0 single (SIO0 in, SIO1 out), 1 dual, 2/3 quad; sampled at CS fall
//  i_Dir_TX       in     1  modes 1-3 only: 1 = slave drives SIO, 0 = slave samples SIO
//  i_TX_Byte      in     8  next byte to return to the master
//  i_TX_DV        in     1  load i_TX_Byte; accepted only while o_TX_Ready=1
//  o_TX_Ready     out    1  TX holding register empty
//  o_RX_DV        out    1  one-cycle pulse; o_RX_Byte is valid
//  o_RX_Byte      out    8  last complete byte received
//  i_SPI_Clk      in     1  SPI clock from master
//  i_SPI_CS_n     in     1  chip select, active low
//  SIO            inout  4  serial data lines
//  o_Underrun     out    1  [SPI_SLAVE_STATUS_EN] sticky: DEFAULT_TX was sent
//  o_Overrun      out    1  [SPI_SLAVE_STATUS_EN] sticky: i_TX_DV while not ready
// BEHAVIOUR
//  Reset
//   - o_TX_Ready=1; o_RX_DV=0; o_RX_Byte=0; status flags=0.
//   - SIO all Z; FSM to IDLE; holding register empty.
//  Synchronizers and edges
//   - i_SPI_Clk, i_SPI_CS_n and SIO pass through SYNC_STAGES flops; edges come from the synchronized values.
//   - Leading/trailing edge follows CPOL.
//   - Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
//  Bits per edge (BPE) and lane mapping
//   - BPE = 1/2/4 for single/dual/quad; a byte completes after 8/BPE sample edges.
//   - Dual: SIO1=b7, SIO0=b6, then b5/b4, and so on.
//   - Quad: SIO3..0 = b7..b4, then b3..b0.
//   - Single: RX on SIO0, TX on SIO1.
//  FSM
//   - IDLE -> ACTIVE on synchronized CS fall. On that transition:
//     - latch bus mode and direction;
//     - load the TX shift register from the holding register, or DEFAULT_TX if empty.
//     - CPHA=0: present the first output bits in the same cycle.
//   - ACTIVE, sample edge: shift in BPE bits. On the last edge of a byte:
//     - o_RX_Byte updates and o_RX_DV pulses the next cycle;
//     - the bit counter wraps to 0.
//   - ACTIVE, shift edge: present the next BPE bits.
//     - CPHA=1: the first shift edge presents b7.
//     - When the previous byte is exhausted, reload the shift register from holding/DEFAULT_TX first.
//   - ACTIVE -> IDLE on synchronized CS rise, mid-byte included:
//     - partial RX discarded, no o_RX_DV;
//     - partial TX shift contents discarded; the holding register is kept.
//  Output enables
//   - Single mode: SIO1 driven while ACTIVE.
//   - Modes 1-3: lanes 0..BPE-1 driven only while ACTIVE and i_Dir_TX=1. All others are Z.
//   - Modes 1-3 are half-duplex: RX bytes are produced only when i_Dir_TX=0.
//  TX handshake
//   - A reload empties the holding register and sets o_TX_Ready=1 the next cycle.
//   - i_TX_DV on the same cycle as a reload with an empty holding register goes straight into the shift register; no underrun.
//   - i_TX_DV while o_TX_Ready=0 is ignored.
//  Reset mid-transfer: immediate return to reset state; the next byte starts only after a fresh CS fall.
// CONFIGURATION
//  SPI_SLAVE_STATUS_EN defined:
//   - o_Underrun sets when DEFAULT_TX is loaded while ACTIVE.
//   - o_Overrun sets on i_TX_DV with o_TX_Ready=0.
//   - Both flags clear only on i_Rst.
//  SPI_SLAVE_STATUS_EN undefined: both ports absent, no flag logic.
// STRUCTURE
//  - spi_defs.vh (shared with spi_master): bus-mode codes, CPOL/CPHA decode, BPE function.
//  - Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs.
//    One instance for the SPI clock, one for CS_n; SIO uses the synchronizer only.
// TESTING
//  1. Mode 0, single, TX queued 8'hA5, master sends 8'h3C -> o_RX_Byte=8'h3C with a 1-cycle o_RX_DV; master receives 8'hA5.
//  2. Dual, i_Dir_TX=1, byte 8'hC6 -> SIO1/SIO0 pairs 11,00,01,10 on 4 edges; o_TX_Ready rises after the reload.
//  3. Quad RX, SPI_MODE 3, master sends 8'h9E -> o_RX_Byte=8'h9E after 2 sample edges.
//  4. CS rises after 5 of 8 single-mode bits -> no o_RX_DV; next full byte 8'h81 -> o_RX_Byte=8'h81.
//  5. Two bytes, no TX queued -> master reads 8'hFF twice; o_Underrun=1 (STATUS_EN build).
//  6. i_Rst pulsed mid-byte -> SIO Z, o_TX_Ready=1, o_RX_Byte=0 next cycle.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: bus-mode codes, CPOL/CPHA decode and
// bits-per-edge lookup. Imported by the spi_slave top.
package spi_slave_pkg;

  localparam logic [1:0] BUS_SINGLE = 2'd0;
  localparam logic [1:0] BUS_DUAL   = 2'd1;
  localparam logic [1:0] BUS_QUAD   = 2'd2;

  // Clock polarity is bit 1 of the SPI mode number.
  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Clock phase is bit 0 of the SPI mode number.
  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

  // Bits moved per sample/shift edge for a given bus mode.
  function automatic logic [2:0] bus_bpe(input logic [1:0] bus_mode);
    case (bus_mode)
      BUS_SINGLE: return 3'd1;
      BUS_DUAL:   return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Byte-level ready/valid interface between spi_slave and its client.
// Status flags exist only when SPI_SLAVE_STATUS_EN is defined.
interface spi_slave_if;

  logic [1:0] bus_mode;
  logic       dir_tx;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;
`ifdef SPI_SLAVE_STATUS_EN
  logic       underrun;
  logic       overrun;
`endif

  modport slave (
    input  bus_mode, dir_tx, tx_byte, tx_dv,
    output tx_ready, rx_dv, rx_byte
`ifdef SPI_SLAVE_STATUS_EN
    , output underrun, overrun
`endif
  );

  modport master (
    output bus_mode, dir_tx, tx_byte, tx_dv,
    input  tx_ready, rx_dv, rx_byte
`ifdef SPI_SLAVE_STATUS_EN
    , input underrun, overrun
`endif
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall
// pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Rise,
  output logic o_Fall
);

  // Top bit is one cycle older than the synchronized value, for edge detection.
  logic [STAGES:0] sh_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge i_Clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (i_Rst) sh_q <= {(STAGES + 1){RST_VAL}};
    else       sh_q <= {sh_q[STAGES-1:0], i_Async};
  end

  assign o_Rise =  sh_q[STAGES-1] & ~sh_q[STAGES];
  assign o_Fall = ~sh_q[STAGES-1] &  sh_q[STAGES];

endmodule

// File: rtl/spi_slave.sv
// SPI responder with single/dual/quad lanes, MSB first, oversampled on i_Clk.
// Optional sticky underrun/overrun flags: define SPI_SLAVE_STATUS_EN.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int         SPI_MODE    = 0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  spi_slave_if.slave  bus,
  input  logic        i_SPI_Clk,
  input  logic        i_SPI_CS_n,
  inout  wire  [3:0]  SIO
);

  localparam logic CPOL = mode_cpol(2'(SPI_MODE));
  localparam logic CPHA = mode_cpha(2'(SPI_MODE));

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic       clk_rise, clk_fall, cs_rise, cs_fall;
  logic [3:0] sio_s;
  logic [4*SYNC_STAGES-1:0] sio_sh_q;

  logic [0:0] state_q;
  logic [1:0] mode_q;
  logic       dir_q;
  logic [7:0] tx_sr_q, rx_sr_q, rx_byte_q, hold_q;
  logic [3:0] tx_left_q, rx_cnt_q;
  logic       rx_dv_q, hold_valid_q;

  logic [2:0] bpe;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic       start, reload, load_default, rx_en;
  logic [7:0] next_byte, rx_next;
  logic [3:0] rx_cnt_next;
  logic [3:0] sio_oe, sio_out;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_clk_sync (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_Clk),
    .o_Rise(clk_rise), .o_Fall(clk_fall)
  );

  // CS_n resets to "asserted" so a CS held low across reset never looks like
  // a fresh fall; the slave waits for a real high-to-low transition.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_CS_n),
    .o_Rise(cs_rise), .o_Fall(cs_fall)
  );

  // Synchronize the data lanes with the same depth as the SPI clock.
  always_ff @(posedge i_Clk) begin
    // NOTE: no reset on the data synchronizer; its contents only matter when an edge qualifies them.
    sio_sh_q <= {sio_sh_q[4*SYNC_STAGES-5:0], SIO};
  end
  assign sio_s = sio_sh_q[4*SYNC_STAGES-1 -: 4];

  assign bpe         = bus_bpe(mode_q);
  assign lead_edge   = CPOL ? clk_fall : clk_rise;
  assign trail_edge  = CPOL ? clk_rise : clk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  assign start  = (state_q == ST_IDLE) && cs_fall;
  assign reload = start || ((state_q == ST_ACTIVE) && !cs_rise && shift_edge &&
                            (tx_left_q == {1'b0, bpe}));
  // A same-cycle i_TX_DV into an empty holding register bypasses straight to the shifter.
  assign next_byte    = hold_valid_q ? hold_q : (bus.tx_dv ? bus.tx_byte : DEFAULT_TX);
  assign load_default = reload && !hold_valid_q && !bus.tx_dv;
  assign rx_en        = (mode_q == BUS_SINGLE) || !dir_q;
  assign rx_cnt_next  = rx_cnt_q + {1'b0, bpe};

  // Receive shift value and lane drive for the latched bus mode.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    rx_next = rx_sr_q;
    sio_out = '0;
    sio_oe  = '0;
    case (mode_q)
      BUS_SINGLE: begin
        rx_next    = {rx_sr_q[6:0], sio_s[0]};
        sio_out[1] = tx_sr_q[7];
        sio_oe     = 4'b0010;
      end
      BUS_DUAL: begin
        rx_next      = {rx_sr_q[5:0], sio_s[1:0]};
        sio_out[1:0] = tx_sr_q[7:6];
        sio_oe       = dir_q ? 4'b0011 : 4'b0000;
      end
      default: begin
        rx_next = {rx_sr_q[3:0], sio_s};
        sio_out = tx_sr_q[7:4];
        sio_oe  = dir_q ? 4'b1111 : 4'b0000;
      end
    endcase
    if (state_q != ST_ACTIVE) sio_oe = '0;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sio
    assign SIO[g] = sio_oe[g] ? sio_out[g] : 1'bz;
  end

  // Transfer FSM with the TX/RX shift datapath.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= BUS_SINGLE;
      dir_q     <= 1'b0;
      tx_sr_q   <= '0;
      tx_left_q <= '0;
      rx_sr_q   <= '0;
      rx_cnt_q  <= '0;
      rx_byte_q <= '0;
      rx_dv_q   <= 1'b0;
    end else begin
      rx_dv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_ACTIVE;
            mode_q    <= bus.bus_mode;
            dir_q     <= bus.dir_tx;
            tx_sr_q   <= next_byte;
            // CPHA=1 holds 0 until the first shift edge presents b7.
            tx_left_q <= CPHA ? 4'd0 : 4'd8;
            rx_cnt_q  <= '0;
          end
        end
        default: begin
          if (cs_rise) begin
            state_q   <= ST_IDLE;
            tx_left_q <= '0;
            rx_cnt_q  <= '0;
          end else begin
            if (sample_edge && rx_en) begin
              rx_sr_q <= rx_next;
              if (rx_cnt_next == 4'd8) begin
                rx_byte_q <= rx_next;
                rx_dv_q   <= 1'b1;
                rx_cnt_q  <= '0;
              end else begin
                rx_cnt_q  <= rx_cnt_next;
              end
            end
            if (shift_edge) begin
              if (tx_left_q == 4'd0) begin
                tx_left_q <= 4'd8;
              end else if (reload) begin
                tx_sr_q   <= next_byte;
                tx_left_q <= 4'd8;
              end else begin
                tx_sr_q   <= tx_sr_q << bpe;
                tx_left_q <= tx_left_q - {1'b0, bpe};
              end
            end
          end
        end
      endcase
    end
  end

  // Holding register: filled by the client, emptied by every reload.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (reload) begin
      hold_valid_q <= 1'b0;
    end else if (bus.tx_dv && !hold_valid_q) begin
      hold_valid_q <= 1'b1;
      hold_q       <= bus.tx_byte;
    end
  end

  assign bus.tx_ready = !hold_valid_q;
  assign bus.rx_dv    = rx_dv_q;
  assign bus.rx_byte  = rx_byte_q;

`ifdef SPI_SLAVE_STATUS_EN
  logic underrun_q, overrun_q;

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (load_default)                 underrun_q <= 1'b1;
      if (bus.tx_dv && hold_valid_q)    overrun_q  <= 1'b1;
    end
  end

  assign bus.underrun = underrun_q;
  assign bus.overrun  = overrun_q;
`endif

endmodule
